sha256_msg_ctrl: RTL



---
 rtl/sha256_msg_ctrl_pkg.sv | 41 ++++
 rtl/sha256_msg_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_ctrl_pkg.sv
// Shared definitions for the SHA-256 message sequencer.
//   ctrl_state_t  : sequencer FSM states
//   PAD_WORD      : word carrying the mandatory 0x80 padding byte in its first byte
//   last_word_pad : masks a partial last word and appends the 0x80 byte after the valid bytes
//   word_bits     : number of message bits contributed by an accepted word
package sha256_msg_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCoreRst,
        StFill,
        StPad,
        StLen,
        StIssue,
        StWaitDrop,
        StWaitDone,
        StOut
    } ctrl_state_t;

    localparam logic [31:0] PAD_WORD  = 32'h8000_0000;
    localparam int unsigned BLK_WORDS = 16;

    // nbytes = 0 means a full word: no padding byte fits, returned unchanged.
    function automatic logic [31:0] last_word_pad(input logic [31:0] data,
                                                  input logic [1:0]  nbytes);
        logic [31:0] w_out;
        unique case (nbytes)
            2'd1:    w_out = {data[31:24], 8'h80, 16'h0000};
            2'd2:    w_out = {data[31:16], 8'h80, 8'h00};
            2'd3:    w_out = {data[31:8], 8'h80};
            default: w_out = data;
        endcase
        return w_out;
    endfunction

    // 0 -> 32 bits, 1..3 -> 8/16/24 bits.
    function automatic logic [5:0] word_bits(input logic [1:0] nbytes);
        return {(nbytes == 2'd0), nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_msg_ctrl.sv
// Message sequencer for the sha256 block-compression core.
// Packs a 32-bit big-endian word stream into 512-bit blocks, applies SHA-256 padding and the
// 64-bit bit-length field, issues each block to the core and waits for its result, then
// presents the final digest on a valid/ready interface.
// Ports:
//   clk_i, rstn_i                 : clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_last_i   : message word stream (first byte in [31:24])
//   s_bytes_i, s_ready_o          : valid bytes in last word (0 = 4), stream ready
//   core_blk_o, core_blk_vld_o    : block to core (word i at [32*i +: 32]), start pulse
//   core_rstn_o                   : registered core reset, low one cycle per message
//   core_hash_i, core_hash_vld_i  : core result and level valid
//   digest_o/digest_vld_o/digest_rdy_i : final digest handshake
//   busy_o                        : high whenever not idle
module sha256_msg_ctrl
    import sha256_msg_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LEN_BITS = 64
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [31:0]              s_data_i,
    input  logic                     s_valid_i,
    input  logic                     s_last_i,
    input  logic [1:0]               s_bytes_i,
    output logic                     s_ready_o,
    output logic [511:0]             core_blk_o,
    output logic                     core_blk_vld_o,
    output logic                     core_rstn_o,
    input  logic [255:0]             core_hash_i,
    input  logic                     core_hash_vld_i,
    output logic [255:0]             digest_o,
    output logic                     digest_vld_o,
    input  logic                     digest_rdy_i,
    output logic                     busy_o
);

    ctrl_state_t              r_state;
    ctrl_state_t              w_state_next;
    logic [4:0]               r_wcnt;       // bit 4 flags a full block
    logic [MAX_LEN_BITS-1:0]  r_bitlen;
    logic                     r_last_seen;
    logic                     r_pad80_done;
    logic                     r_final_blk;
    logic [31:0]              r_blk_buf [BLK_WORDS];
    logic [255:0]             r_digest;
    logic                     r_core_rstn;

    logic                     w_accept;
    logic [4:0]               w_wcnt_inc;
    logic [5:0]               w_add_bits;
    logic [63:0]              w_len64;
    logic                     w_len_slot;

    assign w_accept   = s_valid_i && (r_state == StFill);
    assign w_wcnt_inc = r_wcnt + 5'd1;
    assign w_add_bits = s_last_i ? word_bits(s_bytes_i) : 6'd32;
    assign w_len64    = 64'(r_bitlen);
    // Padding has reached the length slot of a block that already holds the 0x80 byte.
    assign w_len_slot = (r_wcnt == 5'd14) && r_pad80_done;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (s_valid_i) w_state_next = StCoreRst;
            StCoreRst:  w_state_next = StFill;
            StFill: begin
                if (w_accept) begin
                    if (w_wcnt_inc[4])  w_state_next = StIssue;
                    else if (s_last_i)  w_state_next = StPad;
                end
            end
            StPad: begin
                if (w_len_slot)          w_state_next = StLen;
                else if (w_wcnt_inc[4])  w_state_next = StIssue;
            end
            StLen:      w_state_next = StIssue;
            StIssue:    w_state_next = StWaitDrop;
            StWaitDrop: if (!core_hash_vld_i) w_state_next = StWaitDone;
            StWaitDone: begin
                if (core_hash_vld_i) begin
                    if (r_final_blk)      w_state_next = StOut;
                    else if (r_last_seen) w_state_next = StPad;
                    else                  w_state_next = StFill;
                end
            end
            StOut:      if (digest_rdy_i) w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        s_ready_o      = (r_state == StFill);
        core_blk_vld_o = (r_state == StIssue);
        digest_vld_o   = (r_state == StOut);
        busy_o         = (r_state != StIdle);
    end

    // Block buffer, counters and digest capture
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wcnt       <= '0;
            r_bitlen     <= '0;
            r_last_seen  <= 1'b0;
            r_pad80_done <= 1'b0;
            r_final_blk  <= 1'b0;
            r_digest     <= '0;
            for (int i = 0; i < BLK_WORDS; i++) r_blk_buf[i] <= '0;
        end else begin
            unique case (r_state)
                StCoreRst: begin
                    r_wcnt       <= '0;
                    r_bitlen     <= '0;
                    r_last_seen  <= 1'b0;
                    r_pad80_done <= 1'b0;
                    r_final_blk  <= 1'b0;
                end
                StFill: begin
                    if (w_accept) begin
                        r_blk_buf[r_wcnt[3:0]] <= s_last_i ? last_word_pad(s_data_i, s_bytes_i)
                                                           : s_data_i;
                        r_wcnt   <= w_wcnt_inc;
                        r_bitlen <= r_bitlen + MAX_LEN_BITS'(w_add_bits);
                        if (s_last_i) begin
                            r_last_seen <= 1'b1;
                            if (s_bytes_i != 2'd0) r_pad80_done <= 1'b1;
                        end
                    end
                end
                StPad: begin
                    if (!w_len_slot) begin
                        r_blk_buf[r_wcnt[3:0]] <= r_pad80_done ? 32'h0 : PAD_WORD;
                        r_pad80_done <= 1'b1;
                        r_wcnt       <= w_wcnt_inc;
                    end
                end
                StLen: begin
                    r_blk_buf[14] <= w_len64[63:32];
                    r_blk_buf[15] <= w_len64[31:0];
                    r_final_blk   <= 1'b1;
                end
                StWaitDone: begin
                    if (core_hash_vld_i) begin
                        r_wcnt <= '0;
                        if (r_final_blk) r_digest <= core_hash_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Low only during the CORE_RST cycle; reset drives it low asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_core_rstn <= 1'b0;
        end else begin
            r_core_rstn <= (w_state_next != StCoreRst);
        end
    end

    always_comb begin
        core_blk_o = '0;
        for (int i = 0; i < BLK_WORDS; i++) core_blk_o[32*i +: 32] = r_blk_buf[i];
    end

    assign core_rstn_o = r_core_rstn;
    assign digest_o    = r_digest;

endmodule
